// File: rtl/multdiv_sched.sv
// Scheduler that issues one multiply or divide to external units and returns a tagged result.
// Optional watchdog on the busy wait: define MULTDIV_TIMEOUT_EN.
module multdiv_sched #(
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [31:0]      data_operandA,
  input  logic [31:0]      data_operandB,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             mult_start,
  output logic             div_start,
  output logic [31:0]      unit_A,
  output logic [31:0]      unit_B,
  input  logic             mult_rdy,
  input  logic             div_rdy,
  input  logic [31:0]      mult_result,
  input  logic [31:0]      div_result,
  input  logic             mult_exc,
  input  logic             div_exc,
  output logic             stall,
  output logic             result_valid,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_exc
);

  typedef enum logic [1:0] {IDLE, MULT_BUSY, DIV_BUSY, DONE} state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_A, r_B, r_result;
  logic [TAG_W-1:0]   r_tag, r_res_tag;
  logic               r_exc, r_mult_start, r_div_start;

  logic               w_accept, w_mult_go, w_div_go, w_cap, w_cap_exc, w_tmo_hit;
  logic [31:0]        w_cap_res;
  logic [TAG_W-1:0]   w_cap_tag;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo;

  // Held at zero outside BUSY, so it reads 0 in the first BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset || !(r_state == MULT_BUSY || r_state == DIV_BUSY)) r_tmo <= '0;
    else                                                          r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo_hit = (r_tmo == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_mult_go = 1'b0;
    w_div_go  = 1'b0;
    w_cap     = 1'b0;
    w_cap_res = '0;
    w_cap_exc = 1'b0;
    w_cap_tag = r_tag;
    unique case (r_state)
      IDLE: begin
        if (!flush && (ctrl_MULT || ctrl_DIV)) begin
          w_accept = 1'b1;
          if (ctrl_MULT && ctrl_DIV) begin
            w_next    = DONE;
            w_cap     = 1'b1;
            w_cap_exc = 1'b1;
            w_cap_tag = req_tag;
          end else if (ctrl_MULT) begin
            w_next    = MULT_BUSY;
            w_mult_go = 1'b1;
          end else begin
            w_next    = DIV_BUSY;
            w_div_go  = 1'b1;
          end
        end
      end
      MULT_BUSY: begin
        if (flush) begin
          w_next = IDLE;
        end else if (mult_rdy) begin
          w_next    = DONE;
          w_cap     = 1'b1;
          w_cap_res = mult_result;
          w_cap_exc = mult_exc;
        end else if (w_tmo_hit) begin
          w_next    = DONE;
          w_cap     = 1'b1;
          w_cap_exc = 1'b1;
        end
      end
      DIV_BUSY: begin
        if (flush) begin
          w_next = IDLE;
        end else if (div_rdy) begin
          w_next    = DONE;
          w_cap     = 1'b1;
          w_cap_res = div_result;
          w_cap_exc = div_exc;
        end else if (w_tmo_hit) begin
          w_next    = DONE;
          w_cap     = 1'b1;
          w_cap_exc = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase

    stall        = !reset && (w_accept || r_state == MULT_BUSY || r_state == DIV_BUSY);
    result_valid = !reset && !flush && (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_A          <= '0;
      r_B          <= '0;
      r_tag        <= '0;
      r_result     <= '0;
      r_res_tag    <= '0;
      r_exc        <= 1'b0;
      r_mult_start <= 1'b0;
      r_div_start  <= 1'b0;
    end else begin
      r_mult_start <= w_mult_go;
      r_div_start  <= w_div_go;
      if (w_accept) begin
        r_A   <= data_operandA;
        r_B   <= data_operandB;
        r_tag <= req_tag;
      end
      if (w_cap) begin
        r_result  <= w_cap_res;
        r_exc     <= w_cap_exc;
        r_res_tag <= w_cap_tag;
      end
    end
  end

  assign mult_start = r_mult_start;
  assign div_start  = r_div_start;
  assign unit_A     = r_A;
  assign unit_B     = r_B;
  assign result     = r_result;
  assign result_tag = r_res_tag;
  assign result_exc = r_exc;

endmodule

// File: tb/tb_multdiv_sched.sv
// Self-checking bench for multdiv_sched: vector table, corner-case sequences, random transactions.
module tb_multdiv_sched;

  logic        clk = 1'b0;
  logic        reset, ctrl_MULT, ctrl_DIV, flush;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  req_tag;
  logic        mult_start, div_start;
  logic [31:0] unit_A, unit_B;
  logic        mult_rdy, div_rdy, mult_exc, div_exc;
  logic [31:0] mult_result, div_result;
  logic        stall, result_valid, result_exc;
  logic [31:0] result;
  logic [4:0]  result_tag;

  always #5 clk = ~clk;

  multdiv_sched #(.TAG_W(5), .TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .req_tag(req_tag),
    .flush(flush), .mult_start(mult_start), .div_start(div_start),
    .unit_A(unit_A), .unit_B(unit_B), .mult_rdy(mult_rdy), .div_rdy(div_rdy),
    .mult_result(mult_result), .div_result(div_result), .mult_exc(mult_exc),
    .div_exc(div_exc), .stall(stall), .result_valid(result_valid), .result(result),
    .result_tag(result_tag), .result_exc(result_exc)
  );

  int errors = 0;
  int checks = 0;

  // Reference: the last result the scheduler should be presenting.
  logic [31:0] m_res;
  logic [4:0]  m_tag;
  logic        m_exc;
  bit          m_valid;

  typedef struct {
    bit          m, d;
    logic [31:0] a, b;
    logic [4:0]  tag;
    int          lat;
    logic [31:0] ures;
    logic        uexc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; flush = 1'b0;
    mult_rdy = 1'b0; div_rdy = 1'b0; mult_exc = 1'b0; div_exc = 1'b0;
    mult_result = '0; div_result = '0;
  endtask

  // One transaction from IDLE; the bench plays the role of both units.
  task automatic run_txn(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, input int lat, input logic [31:0] ures,
                         input logic uexc);
    int sm = 0;
    int sd = 0;
    logic [31:0] e_res;
    logic        e_exc;
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b; req_tag = tg;
    #1;
    chk("accept_stall", 32'(stall), 32'd1);
    chk("accept_valid", 32'(result_valid), 32'd0);
    tick;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom; req_tag = 5'($urandom);
    if (m && d) begin
      e_res = '0; e_exc = 1'b1;
    end else begin
      e_res = ures; e_exc = uexc;
      for (int c = 0; c <= lat; c++) begin
        ctrl_MULT = 1'($urandom_range(0, 1));
        ctrl_DIV  = 1'($urandom_range(0, 1));
        if (m) begin
          mult_rdy = (c == lat); mult_result = ures; mult_exc = uexc;
          div_rdy = 1'($urandom_range(0, 1)); div_result = $urandom; div_exc = 1'($urandom_range(0, 1));
        end else begin
          div_rdy = (c == lat); div_result = ures; div_exc = uexc;
          mult_rdy = 1'($urandom_range(0, 1)); mult_result = $urandom; mult_exc = 1'($urandom_range(0, 1));
        end
        #1;
        sm += int'(mult_start);
        sd += int'(div_start);
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_valid", 32'(result_valid), 32'd0);
        if (c == 0) begin
          chk("unit_A", unit_A, a);
          chk("unit_B", unit_B, b);
          if (m_valid) chk("busy_result_hold", result, m_res);
        end
        tick;
      end
      clr_in;
    end
    chk("mult_starts", 32'(sm), (m && !d) ? 32'd1 : 32'd0);
    chk("div_starts", 32'(sd), (d && !m) ? 32'd1 : 32'd0);
    m_res = e_res; m_exc = e_exc; m_tag = tg; m_valid = 1'b1;
    // Requests arriving in DONE must be ignored.
    ctrl_MULT = 1'($urandom_range(0, 1));
    ctrl_DIV  = 1'($urandom_range(0, 1));
    #1;
    chk("done_valid", 32'(result_valid), 32'd1);
    chk("done_result", result, m_res);
    chk("done_tag", 32'(result_tag), 32'(m_tag));
    chk("done_exc", 32'(result_exc), 32'(m_exc));
    chk("done_stall", 32'(stall), 32'd0);
    if (m && d) chk("both_no_start", 32'({mult_start, div_start}), 32'd0);
    tick;
    clr_in;
    #1;
    chk("after_valid", 32'(result_valid), 32'd0);
    chk("after_stall", 32'(stall), 32'd0);
    chk("after_no_start", 32'({mult_start, div_start}), 32'd0);
    chk("after_result_hold", result, m_res);
    chk("after_tag_hold", 32'(result_tag), 32'(m_tag));
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{m:1, d:0, a:32'd1,  b:32'd2,  tag:5'd5,  lat:4, ures:32'd2,  uexc:1'b0};
    tbl[1] = '{m:0, d:1, a:32'd7,  b:32'd0,  tag:5'd9,  lat:2, ures:32'd0,  uexc:1'b1};
    tbl[2] = '{m:1, d:1, a:32'd11, b:32'd13, tag:5'd3,  lat:1, ures:32'd0,  uexc:1'b0};
    tbl[3] = '{m:1, d:0, a:32'hFFFF, b:32'd3, tag:5'd31, lat:1, ures:32'h2FFFD, uexc:1'b0};
    tbl[4] = '{m:0, d:1, a:32'd100, b:32'd7, tag:5'd0,  lat:1, ures:32'd14, uexc:1'b0};
    tbl[5] = '{m:1, d:0, a:32'd0,  b:32'hDEAD, tag:5'd17, lat:7, ures:32'd0, uexc:1'b0};

    clr_in;
    data_operandA = '0; data_operandB = '0; req_tag = '0;
    m_valid = 1'b0; m_res = '0; m_exc = 1'b0; m_tag = '0;

    // Reset overrides a concurrent request.
    reset = 1'b1; ctrl_MULT = 1'b1;
    tick; tick;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0; ctrl_MULT = 1'b0;
    #1;
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", 32'(result_tag), 32'd0);
    chk("rst_exc", 32'(result_exc), 32'd0);
    chk("rst_unitA", unit_A, 32'd0);
    chk("rst_unitB", unit_B, 32'd0);
    chk("rst_starts", 32'({mult_start, div_start}), 32'd0);
    m_valid = 1'b1;

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].lat, tbl[i].ures, tbl[i].uexc);

    // Flush coincident with mult_rdy, then a divide accepted right after.
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4; req_tag = 5'd12;
    tick; ctrl_MULT = 1'b0;
    #1 chk("fl_mult_start", 32'(mult_start), 32'd1);
    tick; tick;
    mult_rdy = 1'b1; mult_result = 32'd12; flush = 1'b1;
    #1 chk("fl_valid", 32'(result_valid), 32'd0);
    tick;
    clr_in; ctrl_DIV = 1'b1; data_operandA = 32'd50; data_operandB = 32'd5; req_tag = 5'd7;
    #1;
    chk("fl_idle_accept", 32'(stall), 32'd1);
    chk("fl_no_valid", 32'(result_valid), 32'd0);
    chk("fl_result_hold", result, m_res);
    tick; ctrl_DIV = 1'b0;
    #1 chk("fl_div_start", 32'({mult_start, div_start}), 32'd1);
    tick; div_rdy = 1'b1; div_result = 32'd10;
    tick; clr_in;
    #1;
    chk("fl_div_valid", 32'(result_valid), 32'd1);
    chk("fl_div_result", result, 32'd10);
    chk("fl_div_tag", 32'(result_tag), 32'd7);
    m_res = 32'd10; m_tag = 5'd7; m_exc = 1'b0;
    tick;

    // Flush with a request in IDLE drops it.
    ctrl_MULT = 1'b1; flush = 1'b1;
    #1 chk("idle_flush_stall", 32'(stall), 32'd0);
    tick; clr_in;
    #1;
    chk("idle_flush_nostart", 32'(mult_start), 32'd0);
    chk("idle_flush_stall2", 32'(stall), 32'd0);
    tick;

    // No watchdog in the default build: busy waits indefinitely.
    ctrl_DIV = 1'b1;
    tick; ctrl_DIV = 1'b0;
    for (int c = 0; c < 120; c++) begin
      #1;
      chk("hang_stall", 32'(stall), 32'd1);
      chk("hang_valid", 32'(result_valid), 32'd0);
      tick;
    end
    flush = 1'b1;
    tick; flush = 1'b0;
    #1 chk("hang_exit_stall", 32'(stall), 32'd0);
    tick;

    // Flush while in DONE suppresses result_valid.
    ctrl_MULT = 1'b1;
    tick; ctrl_MULT = 1'b0;
    tick; mult_rdy = 1'b1; mult_result = 32'd99;
    tick; mult_rdy = 1'b0; flush = 1'b1;
    #1 chk("done_flush_valid", 32'(result_valid), 32'd0);
    tick; flush = 1'b0;
    #1;
    chk("done_flush_valid2", 32'(result_valid), 32'd0);
    chk("done_flush_stall", 32'(stall), 32'd0);
    m_valid = 1'b0;
    tick;

    // Reset mid-operation; late mult_rdy must be ignored.
    ctrl_MULT = 1'b1; data_operandA = 32'h55; data_operandB = 32'h66; req_tag = 5'd21;
    tick; ctrl_MULT = 1'b0;
    tick; reset = 1'b1;
    #1 chk("midrst_stall", 32'(stall), 32'd0);
    tick; reset = 1'b0; mult_rdy = 1'b1; mult_result = 32'h1234; mult_exc = 1'b1;
    #1;
    chk("midrst_stall2", 32'(stall), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_unitA", unit_A, 32'd0);
    chk("midrst_unitB", unit_B, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_tag", 32'(result_tag), 32'd0);
    chk("midrst_exc", 32'(result_exc), 32'd0);
    chk("midrst_starts", 32'({mult_start, div_start}), 32'd0);
    tick; clr_in;
    #1;
    chk("midrst_late_valid", 32'(result_valid), 32'd0);
    chk("midrst_late_result", result, 32'd0);
    m_res = '0; m_tag = '0; m_exc = 1'b0; m_valid = 1'b1;
    tick;

    for (int i = 0; i < 150; i++) begin
      bit          rm, rd;
      logic [31:0] ra, rb, rr;
      int          sel;
      sel = $urandom_range(0, 9);
      rm = (sel < 5) || (sel == 9);
      rd = (sel >= 5);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (rm) rr = ra * rb;
      else    rr = (rb == 0) ? 32'd0 : ra / rb;
      run_txn(rm, rd, ra, rb, 5'($urandom), $urandom_range(1, 6), rr, 1'(rd && !rm && rb == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
